// File: rtl/otter_ifetch_if.sv
// Fetch-side bus bundle: instruction memory request/response
// and the decode valid/ready handshake.
interface otter_ifetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_inc;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output inst_valid,
    output inst_data,
    output inst_pc,
    output inst_pc_inc,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  inst_valid,
    input  inst_data,
    input  inst_pc,
    input  inst_pc_inc,
    output inst_ready
  );
endinterface

// File: rtl/otter_ifetch.sv
// Instruction fetch front end: PC, credit-limited imem
// requests, redirect flush and a small decode buffer.
module otter_ifetch #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_addr,
  otter_ifetch_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] AMASK = 32'hFFFF_FFFC;

  typedef enum logic {S_RESET, S_RUN} state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q;
  logic [CW-1:0] occ_q;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [31:0]   buf_data [DEPTH];
  logic [31:0]   buf_pc   [DEPTH];
  logic [CW:0]   credit;
  logic [31:0]   rsp_pc;
  logic [31:0]   head_pc;
  logic          req_valid, accept, rsp;
  logic          drop_rsp, push, pop;

  always_comb begin
    state_d   = state_q;
    req_valid = 1'b0;
    unique case (1'b1)
      (state_q == S_RESET): state_d = S_RUN;
      default: req_valid = (credit < (CW+1)'(DEPTH));
    endcase
  end

  assign credit   = {1'b0, occ_q} + {1'b0, outst_q};
  assign accept   = req_valid && bus.imem_req_ready;
  assign rsp      = bus.imem_rsp_valid;
  assign drop_rsp = rsp && (drop_q != '0);
  assign push     = rsp && !drop_rsp && !redirect_valid;
  assign pop      = bus.inst_valid && bus.inst_ready
                 && !redirect_valid;
  assign outst_d  = outst_q + CW'(accept) - CW'(rsp);

  // With nothing left to drop, every outstanding request is on
  // the current sequential path ending just below fetch_pc.
  assign rsp_pc = fetch_pc - (32'(outst_q) << 2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_RESET;
      fetch_pc <= RESET_VEC & AMASK;
      outst_q  <= '0;
      drop_q   <= '0;
      occ_q    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      state_q <= state_d;
      outst_q <= outst_d;
      if (redirect_valid) begin
        fetch_pc <= redirect_addr & AMASK;
        drop_q   <= outst_d;
        occ_q    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
      end else begin
        if (accept)   fetch_pc <= fetch_pc + 32'd4;
        if (drop_rsp) drop_q   <= drop_q - CW'(1);
        if (push)     wr_ptr   <= wr_ptr + AW'(1);
        if (pop)      rd_ptr   <= rd_ptr + AW'(1);
        occ_q <= occ_q + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[wr_ptr] <= bus.imem_rsp_data;
      buf_pc[wr_ptr]   <= rsp_pc;
    end
  end

  assign head_pc            = buf_pc[rd_ptr];
  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc;
  assign bus.inst_valid     = (occ_q != '0);
  assign bus.inst_data      = buf_data[rd_ptr];
  assign bus.inst_pc        = head_pc;
  assign bus.inst_pc_inc    = head_pc + 32'd4;

  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst)
    !(push && occ_q == CW'(DEPTH))
  );
endmodule

// File: tb/tb_otter_ifetch.sv
// Directed bench for otter_ifetch with an in-order imem model
// and a decode-side monitor.
module tb_otter_ifetch;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic [31:0] inc;
  } rec_t;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        mem_ready;
  logic        mem_hold;
  int          tests;
  int          fails;
  rec_t        got[$];
  logic [31:0] acc_q[$];
  logic [31:0] pq[$];

  otter_ifetch_if bus();

  otter_ifetch #(.DEPTH(2), .RESET_VEC(32'h0)) dut (
    .clk(clk),
    .rst(rst),
    .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // imem model (responds >=1 cycle after accept) and monitor
  initial begin
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.imem_req_ready = 1'b0;
    forever begin
      @(negedge clk);
      bus.imem_rsp_valid = 1'b0;
      bus.imem_req_ready = mem_ready;
      if (rst) begin
        pq.delete();
      end else begin
        if (!mem_hold && pq.size() > 0) begin
          bus.imem_rsp_valid = 1'b1;
          bus.imem_rsp_data  = mem_word(pq.pop_front());
        end
        if (bus.imem_req_valid && mem_ready) begin
          pq.push_back(bus.imem_req_addr);
          acc_q.push_back(bus.imem_req_addr);
        end
        if (bus.inst_valid && bus.inst_ready && !redirect_valid)
          got.push_back('{bus.inst_pc, bus.inst_data,
                          bus.inst_pc_inc});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    step();
    step();
    got.delete();
    acc_q.delete();
    rst = 1'b0;
  endtask

  task automatic wait_got(input int n, input string nm);
    for (int i = 0; i < 60 && got.size() < n; i++) step();
    tests++;
    if (got.size() < n) begin
      fails++;
      $display("FAIL %s_timeout: got %0d insts want %0d",
               nm, got.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr = 32'h0;
    inst_ready_set(1'b1);
    mem_ready = 1'b1;
    mem_hold = 1'b0;
    repeat (3) step();
    tests++;
    if (bus.imem_req_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_req_valid: got %b want 0",
               bus.imem_req_valid);
    end
    tests++;
    if (bus.inst_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_inst_valid: got %b want 0",
               bus.inst_valid);
    end
    got.delete();
    acc_q.delete();
    rst = 1'b0;
    tests++;
    if (bus.imem_req_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_state_req: got %b want 0",
               bus.imem_req_valid);
    end
    step();
    tests++;
    if (bus.imem_req_valid !== 1'b1 ||
        bus.imem_req_addr !== 32'h0) begin
      fails++;
      $display("FAIL first_req: got %b/%h want 1/00000000",
               bus.imem_req_valid, bus.imem_req_addr);
    end
  endtask

  task automatic inst_ready_set(input logic v);
    bus.inst_ready = v;
  endtask

  task automatic test_basic();
    step();
    tests++;
    if (bus.inst_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 ||
        bus.imem_req_addr !== 32'h4) begin
      fails++;
      $display("FAIL basic_c1: got iv=%b rv=%b a=%h want 0/1/4",
               bus.inst_valid, bus.imem_req_valid,
               bus.imem_req_addr);
    end
    step();
    tests++;
    if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0 ||
        bus.inst_pc_inc !== 32'h4 ||
        bus.inst_data !== mem_word(32'h0)) begin
      fails++;
      $display("FAIL basic_head: got %b %h %h %h want 1 0 4 %h",
               bus.inst_valid, bus.inst_pc, bus.inst_pc_inc,
               bus.inst_data, mem_word(32'h0));
    end
    tests++;
    if (bus.imem_req_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_credit: got %b want 0",
               bus.imem_req_valid);
    end
    wait_got(6, "basic");
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      tests++;
      if (got[i].pc !== 32'(4*i) || got[i].inc !== 32'(4*i+4) ||
          got[i].data !== mem_word(32'(4*i))) begin
        fails++;
        $display("FAIL basic_seq%0d: got %h/%h/%h want %h/%h/%h",
                 i, got[i].pc, got[i].inc, got[i].data,
                 32'(4*i), 32'(4*i+4), mem_word(32'(4*i)));
      end
    end
    for (int i = 0; i < 3 && i < acc_q.size(); i++) begin
      tests++;
      if (acc_q[i] !== 32'(4*i)) begin
        fails++;
        $display("FAIL basic_req%0d: got %h want %h",
                 i, acc_q[i], 32'(4*i));
      end
    end
  endtask

  task automatic test_stall();
    inst_ready_set(1'b0);
    mem_ready = 1'b1;
    mem_hold = 1'b0;
    do_reset();
    repeat (10) step();
    tests++;
    if (acc_q.size() != 2 || bus.imem_req_valid !== 1'b0) begin
      fails++;
      $display("FAIL stall_credit: got %0d reqs rv=%b want 2/0",
               acc_q.size(), bus.imem_req_valid);
    end
    tests++;
    if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0 ||
        got.size() != 0) begin
      fails++;
      $display("FAIL stall_head: got %b %h n=%0d want 1 0 n=0",
               bus.inst_valid, bus.inst_pc, got.size());
    end
    inst_ready_set(1'b1);
    wait_got(4, "stall");
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      tests++;
      if (got[i].pc !== 32'(4*i)) begin
        fails++;
        $display("FAIL stall_seq%0d: got %h want %h",
                 i, got[i].pc, 32'(4*i));
      end
    end
    tests++;
    if (acc_q.size() < 3 || acc_q[2] !== 32'h8) begin
      fails++;
      $display("FAIL stall_resume: got n=%0d want req 8",
               acc_q.size());
    end
  endtask

  task automatic test_req_stall();
    inst_ready_set(1'b1);
    mem_ready = 1'b0;
    do_reset();
    step();
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (bus.imem_req_valid !== 1'b1 ||
          bus.imem_req_addr !== 32'h0) begin
        fails++;
        $display("FAIL rstall_hold%0d: got %b/%h want 1/0",
                 k, bus.imem_req_valid, bus.imem_req_addr);
      end
      step();
    end
    mem_ready = 1'b1;
    wait_got(2, "rstall");
    tests++;
    if (acc_q.size() < 2 || acc_q[0] !== 32'h0 ||
        acc_q[1] !== 32'h4) begin
      fails++;
      $display("FAIL rstall_once: got n=%0d want reqs 0,4",
               acc_q.size());
    end
    tests++;
    if (got.size() < 2 || got[0].pc !== 32'h0 ||
        got[1].pc !== 32'h4) begin
      fails++;
      $display("FAIL rstall_seq: got n=%0d want pcs 0,4",
               got.size());
    end
  endtask

  task automatic test_redirect_drop();
    inst_ready_set(1'b1);
    mem_ready = 1'b1;
    mem_hold = 1'b1;
    do_reset();
    redirect_valid = 1'b1;
    redirect_addr = 32'h10;
    step();
    redirect_valid = 1'b0;
    step();
    step();
    tests++;
    if (bus.imem_req_valid !== 1'b0 || acc_q.size() != 2 ||
        acc_q[0] !== 32'h10 || acc_q[1] !== 32'h14) begin
      fails++;
      $display("FAIL rdrop_setup: got rv=%b n=%0d want 0/2",
               bus.imem_req_valid, acc_q.size());
    end
    redirect_valid = 1'b1;
    redirect_addr = 32'h103;
    step();
    redirect_valid = 1'b0;
    mem_hold = 1'b0;
    tests++;
    if (bus.imem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0) begin
      fails++;
      $display("FAIL rdrop_credit: got rv=%b iv=%b want 0/0",
               bus.imem_req_valid, bus.inst_valid);
    end
    step();
    tests++;
    if (bus.imem_req_valid !== 1'b1 ||
        bus.imem_req_addr !== 32'h100 || bus.inst_valid !== 1'b0) begin
      fails++;
      $display("FAIL rdrop_newreq: got %b/%h iv=%b want 1/100/0",
               bus.imem_req_valid, bus.imem_req_addr,
               bus.inst_valid);
    end
    wait_got(2, "rdrop");
    tests++;
    if (got.size() < 2 || got[0].pc !== 32'h100 ||
        got[0].data !== mem_word(32'h100) ||
        got[1].pc !== 32'h104) begin
      fails++;
      $display("FAIL rdrop_seq: got n=%0d pc0=%h want 100,104",
               got.size(), got.size() > 0 ? got[0].pc : 32'h0);
    end
  endtask

  task automatic test_redirect_same();
    inst_ready_set(1'b1);
    mem_ready = 1'b1;
    mem_hold = 1'b0;
    do_reset();
    step();
    step();
    tests++;
    if (bus.imem_req_valid !== 1'b1 ||
        bus.imem_req_addr !== 32'h4) begin
      fails++;
      $display("FAIL rsame_setup: got %b/%h want 1/4",
               bus.imem_req_valid, bus.imem_req_addr);
    end
    redirect_valid = 1'b1;
    redirect_addr = 32'h200;
    step();
    redirect_valid = 1'b0;
    tests++;
    if (bus.inst_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 ||
        bus.imem_req_addr !== 32'h200) begin
      fails++;
      $display("FAIL rsame_req: got iv=%b rv=%b a=%h want 0/1/200",
               bus.inst_valid, bus.imem_req_valid,
               bus.imem_req_addr);
    end
    step();
    tests++;
    if (bus.inst_valid !== 1'b0) begin
      fails++;
      $display("FAIL rsame_stale: got iv=%b want 0",
               bus.inst_valid);
    end
    wait_got(2, "rsame");
    tests++;
    if (got.size() < 2 || got[0].pc !== 32'h200 ||
        got[0].data !== mem_word(32'h200) ||
        got[1].pc !== 32'h204) begin
      fails++;
      $display("FAIL rsame_seq: got n=%0d pc0=%h want 200,204",
               got.size(), got.size() > 0 ? got[0].pc : 32'h0);
    end
  endtask

  task automatic test_wrap();
    inst_ready_set(1'b1);
    mem_ready = 1'b1;
    mem_hold = 1'b0;
    do_reset();
    redirect_valid = 1'b1;
    redirect_addr = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    wait_got(2, "wrap");
    tests++;
    if (got.size() < 1 || got[0].pc !== 32'hFFFF_FFFC ||
        got[0].inc !== 32'h0) begin
      fails++;
      $display("FAIL wrap_head: got n=%0d want pc fffffffc inc 0",
               got.size());
    end
    tests++;
    if (got.size() < 2 || got[1].pc !== 32'h0 ||
        got[1].inc !== 32'h4) begin
      fails++;
      $display("FAIL wrap_next: got n=%0d want pc 0 inc 4",
               got.size());
    end
    tests++;
    if (acc_q.size() < 2 || acc_q[0] !== 32'hFFFF_FFFC ||
        acc_q[1] !== 32'h0) begin
      fails++;
      $display("FAIL wrap_req: got n=%0d want fffffffc,0",
               acc_q.size());
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    mem_ready = 1'b1;
    mem_hold = 1'b0;
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr = 32'h0;
    bus.inst_ready = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_req_stall();
    test_redirect_drop();
    test_redirect_same();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
